// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between fetch and data ports: data first, instruction starvation bounded.
// Hit pulses two edges after grant at best; one access in flight; requests are level-held until their hit.
module mem_arbiter #(
  parameter int DPRIO_LIMIT = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_rdy,
  output logic        mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam bit          DL_EN   = (DPRIO_LIMIT > 0);
  localparam bit          WD_EN   = (TIMEOUT > 0);
  localparam logic [31:0] DLIM    = 32'(DPRIO_LIMIT);
  localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic [1:0]  state;
  logic [31:0] starve;
  logic [31:0] wd_cnt;
  logic        force_i;
  logic        grant_d;
  logic        grant_i;
  logic        wd_expire;

  always_comb begin
    force_i   = DL_EN && iREN && (starve == DLIM);
    grant_d   = (dREN || dWEN) && !force_i;
    grant_i   = iREN && !grant_d;
    wd_expire = WD_EN && (wd_cnt == WD_LAST);
  end

  // The RAM strobes double as the latched access type: ramWEN high means a data write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      starve   <= '0;
      wd_cnt   <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      mem_err  <= 1'b0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (grant_d) begin
            state    <= DACC;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
            if (!iREN)
              starve <= '0;
            else if (starve != DLIM)
              starve <= starve + 32'd1;
          end else if (grant_i) begin
            state    <= IACC;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            ramaddr  <= iaddr;
            ramstore <= '0;
            starve   <= '0;
          end
        end
        IACC, DACC: begin
          // Completion takes precedence over a watchdog expiry in the same cycle.
          if (ram_rdy) begin
            state  <= DONE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (state == IACC) begin
              ihit  <= 1'b1;
              iload <= ramload;
            end else begin
              dhit <= 1'b1;
              if (ramREN)
                dload <= ramload;
            end
          end else if (wd_expire) begin
            state   <= IDLE;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM responder, requesters, and a grant/hit scoreboard checked at negedge.
module tb_mem_arbiter;

  localparam int DPRIO_LIMIT = 4;
  localparam int TIMEOUT     = 64;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN, ram_rdy;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.DPRIO_LIMIT(DPRIO_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_rdy(ram_rdy), .mem_err(mem_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;
  int nhits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // RAM contents; unwritten words read back as an address-derived pattern
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // RAM responder: fixed_lat ACC cycles before ram_rdy (-1 = never), or random per access
  int fixed_lat = 0;
  bit rand_lat  = 0;
  bit spurious  = 0;

  initial begin
    int acc_n;
    int cur_lat;
    acc_n   = 0;
    cur_lat = 0;
    ram_rdy = 1'b0;
    ramload = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (ramREN || ramWEN) begin
        if (acc_n == 0)
          cur_lat = rand_lat ? int'($urandom_range(0, 4)) : fixed_lat;
        if (cur_lat >= 0 && acc_n == cur_lat) begin
          ram_rdy = 1'b1;
          if (ramWEN) mem[ramaddr] = ramstore;
          ramload = ramREN ? rd(ramaddr) : $urandom;
        end else begin
          ram_rdy = 1'b0;
          ramload = $urandom;
        end
        acc_n++;
      end else begin
        acc_n   = 0;
        ram_rdy = spurious && ($urandom_range(0, 5) == 0);
        ramload = $urandom;
      end
    end
  end

  // Scoreboard: a grant pushes the expected hit, completion pops and compares
  typedef struct packed {
    logic        is_d;
    logic        is_wr;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  bit          mon_en = 1;
  int          dstreak = 0;
  logic        p_iren, p_dren, p_dwen, p_strobe, p_rdy, p_idle, g_wr;
  logic [31:0] p_iaddr, p_daddr, p_dstore, g_addr;

  always @(negedge CLK) begin
    logic        strobe;
    logic        exp_d;
    logic [31:0] ea;
    exp_t        e;
    strobe = ramREN | ramWEN;
    if (!mon_en || RST) begin
      expq.delete();
      dstreak  = 0;
      p_strobe = 1'b0;
      p_rdy    = 1'b0;
      p_idle   = 1'b0;
    end else begin
      chk("one_strobe", 32'(ramREN & ramWEN), 32'd0);
      chk("one_hit", 32'(ihit & dhit), 32'd0);
      if (ihit || dhit) begin
        if (!(p_strobe && p_rdy))
          chk("hit_without_rdy", 32'({ihit, dhit}), 32'd0);
        else if (expq.size() == 0)
          chk("hit_unexpected", 32'({ihit, dhit}), 32'd0);
        else begin
          e = expq.pop_front();
          nhits++;
          chk("hit_kind", 32'({ihit, dhit}), e.is_d ? 32'd1 : 32'd2);
          if (!e.is_wr) chk(e.is_d ? "dload" : "iload", e.is_d ? dload : iload, e.data);
          chk("strobe_after_done", 32'(strobe), 32'd0);
        end
      end else if (p_strobe && p_rdy) begin
        chk("hit_missing", 32'({ihit, dhit}), (expq.size() > 0 && expq[0].is_d) ? 32'd1 : 32'd2);
      end
      if (strobe && !p_strobe) begin
        if (!(p_iren || p_dren || p_dwen)) begin
          chk("grant_no_req", 32'(strobe), 32'd0);
        end else begin
          exp_d = (p_dren || p_dwen) &&
                  !(DPRIO_LIMIT != 0 && p_iren && dstreak == DPRIO_LIMIT);
          ea = exp_d ? p_daddr : p_iaddr;
          chk("grant_addr", ramaddr, ea);
          chk("grant_wen", 32'(ramWEN), 32'(exp_d && p_dwen));
          if (exp_d && p_dwen) chk("grant_store", ramstore, p_dstore);
          e.is_d  = exp_d;
          e.is_wr = exp_d && p_dwen;
          e.data  = rd(ea);
          expq.push_back(e);
          g_addr = ea;
          g_wr   = e.is_wr;
          if (exp_d && p_iren) begin
            if (dstreak < DPRIO_LIMIT) dstreak++;
          end else begin
            dstreak = 0;
          end
        end
      end else if (strobe) begin
        chk("acc_addr_stable", ramaddr, g_addr);
        chk("acc_wen_stable", 32'(ramWEN), 32'(g_wr));
      end
      if (p_idle && (p_iren || p_dren || p_dwen)) chk("grant_missing", 32'(strobe), 32'd1);
      if (p_strobe && !p_rdy) chk("acc_held", 32'(strobe), 32'd1);
      p_strobe = strobe;
      p_rdy    = ram_rdy;
      p_idle   = !strobe && !ihit && !dhit;
    end
    p_iren   = iREN;
    p_dren   = dREN;
    p_dwen   = dWEN;
    p_iaddr  = iaddr;
    p_daddr  = daddr;
    p_dstore = dstore;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_hit(input bit d, input int bound, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(d ? dhit : ihit) && cyc < bound);
    if (!(d ? dhit : ihit)) chk(d ? "wait_dhit" : "wait_ihit", 32'(d ? dhit : ihit), 32'd1);
  endtask

  task automatic wait_strobe(input int bound);
    int c;
    c = 0;
    while (!(ramREN || ramWEN) && c < bound) begin
      tick();
      c++;
    end
    if (!(ramREN || ramWEN)) chk("wait_strobe", 32'(ramREN | ramWEN), 32'd1);
  endtask

  initial begin
    int         cyc, nh, n, hits, errhold;
    logic [5:0] order;
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_flags", 32'({ihit, dhit, ramREN, ramWEN, mem_err}), 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    RST = 1'b0;
    tick();

    // Instruction fetch, RAM ready one cycle after the strobe
    mem[32'h40] = 32'h2008_000A;
    fixed_lat = 1;
    iREN = 1'b1; iaddr = 32'h40;
    wait_hit(0, 10, cyc);
    chk("t1_latency", 32'(cyc), 32'd3);
    chk("t1_iload", iload, 32'h2008_000A);
    iREN = 1'b0;
    repeat (2) tick();

    // Simultaneous write and fetch: write first, then fetch
    fixed_lat = 0;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    iREN = 1'b1; iaddr = 32'h44;
    tick();
    chk("t2_wen", 32'(ramWEN), 32'd1);
    chk("t2_ren", 32'(ramREN), 32'd0);
    chk("t2_addr", ramaddr, 32'h100);
    chk("t2_store", ramstore, 32'hDEAD_BEEF);
    wait_hit(1, 10, cyc);
    chk("t2_latency", 32'(cyc + 1), 32'd2);
    dWEN = 1'b0;
    repeat (2) tick();
    chk("t2_then_fetch", 32'({ramREN, ramWEN}), 32'd2);
    chk("t2_fetch_addr", ramaddr, 32'h44);
    wait_hit(0, 10, cyc);
    iREN = 1'b0;
    chk("t2_mem", rd(32'h100), 32'hDEAD_BEEF);
    repeat (2) tick();

    // Both held continuously: four data grants, then one fetch
    dREN = 1'b1; daddr = 32'h200;
    iREN = 1'b1; iaddr = 32'h80;
    order = '0; nh = 0;
    for (int c = 0; c < 100 && nh < 6; c++) begin
      tick();
      if (ihit || dhit) begin
        order = {order[4:0], dhit};
        nh++;
      end
    end
    dREN = 1'b0; iREN = 1'b0;
    chk("t3_order", 32'(order), 32'b111101);
    repeat (3) tick();

    // Data read dropped after grant still completes, then the waiting fetch goes
    fixed_lat = 2;
    iREN = 1'b1; iaddr = 32'h84;
    dREN = 1'b1; daddr = 32'h204;
    tick();
    chk("t4_grant_d", ramaddr, 32'h204);
    dREN = 1'b0;
    wait_hit(1, 10, cyc);
    chk("t4_dload", dload, rd(32'h204));
    wait_hit(0, 10, cyc);
    chk("t4_iload", iload, rd(32'h84));
    iREN = 1'b0;
    repeat (2) tick();

    // Reset during a data access: strobes clear, no hit
    fixed_lat = -1;
    dREN = 1'b1; daddr = 32'h208;
    wait_strobe(10);
    repeat (2) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0; dREN = 1'b0;
    chk("t5_strobes", 32'({ramREN, ramWEN}), 32'd0);
    hits = 0;
    repeat (10) begin
      tick();
      hits += int'(dhit);
    end
    chk("t5_no_dhit", 32'(hits), 32'd0);

    // Watchdog: RAM never ready
    mon_en = 0;
    iREN = 1'b1; iaddr = 32'h88;
    wait_strobe(10);
    iREN = 1'b0;
    n = 1; hits = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      hits += int'(ihit);
      if (!(ramREN || ramWEN)) break;
      n++;
    end
    chk("t6_acc_cycles", 32'(n), 32'(TIMEOUT));
    chk("t6_mem_err", 32'(mem_err), 32'd1);
    errhold = 1;
    repeat (10) begin
      tick();
      hits += int'(ihit);
      errhold = errhold & int'(mem_err);
    end
    chk("t6_err_sticky", 32'(errhold), 32'd1);
    chk("t6_no_hit", 32'(hits), 32'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t6_err_clear", 32'(mem_err), 32'd0);
    mon_en = 1;
    tick();

    // Randomized traffic against the scoreboard
    rand_lat = 1; spurious = 1;
    nhits = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (iREN && ihit) iREN = 1'b0;
      else if (!iREN && $urandom_range(0, 3) == 0) begin
        iREN  = 1'b1;
        iaddr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      end
      if ((dREN || dWEN) && dhit) begin
        dREN = 1'b0; dWEN = 1'b0;
      end else if (!dREN && !dWEN && $urandom_range(0, 2) == 0) begin
        n      = int'($urandom_range(0, 3));
        dREN   = (n != 2);
        dWEN   = (n >= 2);
        daddr  = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
        dstore = $urandom;
      end
    end
    for (int c = 0; c < 300; c++) begin
      tick();
      if (iREN && ihit) iREN = 1'b0;
      if ((dREN || dWEN) && dhit) begin
        dREN = 1'b0; dWEN = 1'b0;
      end
      if (!iREN && !dREN && !dWEN && !ramREN && !ramWEN && expq.size() == 0) break;
    end
    chk("drain_queue", 32'(expq.size()), 32'd0);
    chk("rand_activity", 32'(nhits > 100), 32'd1);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 2000000", $time);
    $fatal(1);
  end

endmodule
